// File: rtl/cle_label_stats.sv
// Label statistics: scans the labelled image from the label SRAM and streams
// area and bounding box per non-empty label. Optional CLE_LABEL_STATS_CENTROID_EN adds x/y sums.
module cle_label_stats #(
   parameter  int unsigned IMG_W      = 32,
   parameter  int unsigned IMG_H      = 32,
   parameter  int unsigned MAX_LABELS = 7,
   parameter  int unsigned LBL_W      = 8,
   localparam int unsigned XW         = $clog2(IMG_W),
   localparam int unsigned YW         = $clog2(IMG_H),
   localparam int unsigned AW         = XW + YW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [AW-1:0]    sram_a,
   input  logic [LBL_W-1:0] sram_q,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LBL_W-1:0] out_label,
   output logic [AW:0]      out_area,
   output logic [XW-1:0]    out_xmin,
   output logic [XW-1:0]    out_xmax,
   output logic [YW-1:0]    out_ymin,
   output logic [YW-1:0]    out_ymax
`ifdef CLE_LABEL_STATS_CENTROID_EN
   ,
   output logic [AW+XW-1:0] out_sumx,
   output logic [AW+YW-1:0] out_sumy
`endif
);

   localparam int unsigned KW = $clog2(MAX_LABELS + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, EMIT, DONE} state_t;

   state_t state, state_nx;

   logic [KW-1:0] k;
   logic [AW-1:0] pa;
   logic          pix_vld;
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   logic          last_k;
   logic          cur_empty;

   logic [AW:0]   area [1:MAX_LABELS];
   logic [XW-1:0] xmin [1:MAX_LABELS];
   logic [XW-1:0] xmax [1:MAX_LABELS];
   logic [YW-1:0] ymin [1:MAX_LABELS];
   logic [YW-1:0] ymax [1:MAX_LABELS];
`ifdef CLE_LABEL_STATS_CENTROID_EN
   logic [AW+XW-1:0] sumx [1:MAX_LABELS];
   logic [AW+YW-1:0] sumy [1:MAX_LABELS];
`endif

   always_comb begin
      px        = pa[XW-1:0];
      py        = pa[AW-1:XW];
      last_k    = (k == KW'(MAX_LABELS));
      cur_empty = (area[k] == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = CLEAR;
         CLEAR: state_nx = SCAN;
         SCAN:  if (sram_a == '1) state_nx = DRAIN;
         DRAIN: state_nx = EMIT;
         EMIT:  if (last_k && ((!out_valid && cur_empty) || (out_valid && out_ready)))
                   state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sram_a    <= '0;
         pa        <= '0;
         pix_vld   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         k         <= KW'(1);
         out_valid <= 1'b0;
         out_label <= '0;
         out_area  <= '0;
         out_xmin  <= '0;
         out_xmax  <= '0;
         out_ymin  <= '0;
         out_ymax  <= '0;
`ifdef CLE_LABEL_STATS_CENTROID_EN
         out_sumx  <= '0;
         out_sumy  <= '0;
`endif
         for (int unsigned i = 1; i <= MAX_LABELS; i++) begin
            area[i] <= '0;
            xmin[i] <= '0;
            xmax[i] <= '0;
            ymin[i] <= '0;
            ymax[i] <= '0;
`ifdef CLE_LABEL_STATS_CENTROID_EN
            sumx[i] <= '0;
            sumy[i] <= '0;
`endif
         end
      end else begin
         // sram_q lags sram_a by one cycle; pa/pix_vld track which address it belongs to
         pa      <= sram_a;
         pix_vld <= (state == SCAN);
         busy    <= (state_nx != IDLE);
         done    <= (state_nx == DONE);

         case (state)
            CLEAR: begin
               sram_a <= '0;
               ovf    <= 1'b0;
               k      <= KW'(1);
               for (int unsigned i = 1; i <= MAX_LABELS; i++) begin
                  area[i] <= '0;
                  xmin[i] <= '1;
                  xmax[i] <= '0;
                  ymin[i] <= '1;
                  ymax[i] <= '0;
`ifdef CLE_LABEL_STATS_CENTROID_EN
                  sumx[i] <= '0;
                  sumy[i] <= '0;
`endif
               end
            end
            SCAN: if (sram_a != '1) sram_a <= sram_a + 1'b1;
            EMIT: begin
               if (!out_valid) begin
                  if (!cur_empty) begin
                     out_valid <= 1'b1;
                     out_label <= LBL_W'(k);
                     out_area  <= area[k];
                     out_xmin  <= xmin[k];
                     out_xmax  <= xmax[k];
                     out_ymin  <= ymin[k];
                     out_ymax  <= ymax[k];
`ifdef CLE_LABEL_STATS_CENTROID_EN
                     out_sumx  <= sumx[k];
                     out_sumy  <= sumy[k];
`endif
                  end else if (!last_k) begin
                     k <= k + 1'b1;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  if (!last_k) k <= k + 1'b1;
               end
            end
            default: ;
         endcase

         if (pix_vld) begin
            for (int unsigned i = 1; i <= MAX_LABELS; i++) begin
               if (sram_q == LBL_W'(i)) begin
                  area[i] <= area[i] + 1'b1;
                  if (px < xmin[i]) xmin[i] <= px;
                  if (px > xmax[i]) xmax[i] <= px;
                  if (py < ymin[i]) ymin[i] <= py;
                  if (py > ymax[i]) ymax[i] <= py;
`ifdef CLE_LABEL_STATS_CENTROID_EN
                  sumx[i] <= sumx[i] + (AW+XW)'(px);
                  sumy[i] <= sumy[i] + (AW+YW)'(py);
`endif
               end
            end
            if (sram_q > LBL_W'(MAX_LABELS)) ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cle_label_stats.sv
// Bench for cle_label_stats: synchronous SRAM model, record scoreboard queue,
// table of single-rectangle images plus hand sequences for handshake/reset corners.
module tb_cle_label_stats;

   logic        clk = 1'b0;
   logic        reset, start, out_ready;
   logic [9:0]  sram_a;
   logic [7:0]  sram_q;
   logic        busy, done, ovf, out_valid;
   logic [7:0]  out_label;
   logic [10:0] out_area;
   logic [4:0]  out_xmin, out_xmax, out_ymin, out_ymax;
`ifdef CLE_LABEL_STATS_CENTROID_EN
   logic [14:0] out_sumx, out_sumy;
`endif

   typedef struct {
      logic [7:0]  lbl;
      logic [10:0] area;
      logic [4:0]  xmin, xmax, ymin, ymax;
      logic [14:0] sx, sy;
   } rec_t;

   typedef struct {
      logic [7:0] lbl;
      int         x0, x1, y0, y1;
      int         area;
   } vec_t;

   logic [7:0] mem [1024];
   rec_t       exp_q [$];
   rec_t       e;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       rand_ready = 1'b0;
   logic       ready_force = 1'b1;

   always #5 clk = ~clk;

   always @(posedge clk) sram_q <= mem[sram_a];

   cle_label_stats #(
      .IMG_W(32), .IMG_H(32), .MAX_LABELS(7), .LBL_W(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .sram_a(sram_a), .sram_q(sram_q),
      .busy(busy), .done(done), .ovf(ovf),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_label(out_label), .out_area(out_area),
      .out_xmin(out_xmin), .out_xmax(out_xmax),
      .out_ymin(out_ymin), .out_ymax(out_ymax)
`ifdef CLE_LABEL_STATS_CENTROID_EN
      , .out_sumx(out_sumx), .out_sumy(out_sumy)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_fields(input string tag, input rec_t r);
      check({tag, "_label"}, out_label, r.lbl);
      check({tag, "_area"},  out_area,  r.area);
      check({tag, "_xmin"},  out_xmin,  r.xmin);
      check({tag, "_xmax"},  out_xmax,  r.xmax);
      check({tag, "_ymin"},  out_ymin,  r.ymin);
      check({tag, "_ymax"},  out_ymax,  r.ymax);
`ifdef CLE_LABEL_STATS_CENTROID_EN
      check({tag, "_sumx"},  out_sumx,  r.sx);
      check({tag, "_sumy"},  out_sumy,  r.sy);
`endif
   endtask

   // Scoreboard: a record is consumed when valid&&ready is seen ahead of the edge
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_record actual_label=%0d required=none", out_label);
         end else begin
            e = exp_q.pop_front();
            check_fields("rec", e);
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_force;
      end
   end

   task automatic clear_mem;
      for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
   endtask

   task automatic fill_rect(input logic [7:0] lbl, input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            mem[y*32 + x] = lbl;
   endtask

   task automatic push_exp(input logic [7:0] lbl, input int x0, input int x1,
                           input int y0, input int y1, input int area);
      rec_t r;
      int   w, h;
      w = x1 - x0 + 1;
      h = y1 - y0 + 1;
      r.lbl  = lbl;
      r.area = 11'(area);
      r.xmin = 5'(x0);
      r.xmax = 5'(x1);
      r.ymin = 5'(y0);
      r.ymax = 5'(y1);
      r.sx   = 15'(h * (x0 + x1) * w / 2);
      r.sy   = 15'(w * (y0 + y1) * h / 2);
      exp_q.push_back(r);
   endtask

   task automatic pulse_start;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   // n counts edges after the one that sampled start
   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (!done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_seen", done, 1);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("busy_low_after_done", busy, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   vec_t tbl [6];
   int   n;

   initial begin
      tbl[0] = '{lbl: 8'd3, x0: 10, x1: 19, y0: 4,  y1: 6,  area: 30};
      tbl[1] = '{lbl: 8'd7, x0: 0,  x1: 31, y0: 0,  y1: 31, area: 1024};
      tbl[2] = '{lbl: 8'd5, x0: 0,  x1: 0,  y0: 31, y1: 31, area: 1};
      tbl[3] = '{lbl: 8'd4, x0: 31, x1: 31, y0: 0,  y1: 31, area: 32};
      tbl[4] = '{lbl: 8'd1, x0: 5,  x1: 8,  y0: 9,  y1: 9,  area: 4};
      tbl[5] = '{lbl: 8'd6, x0: 0,  x1: 31, y0: 15, y1: 16, area: 64};

      reset = 1'b1;
      start = 1'b0;
      clear_mem();
      repeat (3) @(posedge clk);
      #1;
      check("rst_sram_a", sram_a, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_label", out_label, 0);
      check("rst_out_area", out_area, 0);
      reset = 1'b0;

      // Empty image: 1026 cycles to EMIT, 7 skip cycles, then DONE
      pulse_start();
      wait_done(0, n);
      check("empty_done_latency", n, 1033);
      check("empty_ovf", ovf, 0);

      // Corner pixels: first and last address (last one goes through DRAIN)
      clear_mem();
      mem[0]    = 8'd1;
      mem[1023] = 8'd2;
      push_exp(8'd1, 0, 0, 0, 0, 1);
      push_exp(8'd2, 31, 31, 31, 31, 1);
      pulse_start();
      wait_done(0, n);
      check("corner_done_latency", n, 1035);

      // Backpressure: label 3 loads after two skip cycles, then stalls 20 cycles
      clear_mem();
      fill_rect(8'd3, 10, 19, 4, 6);
      ready_force = 1'b0;
      push_exp(8'd3, 10, 19, 4, 6, 30);
      pulse_start();
      n = 0;
      while (!out_valid && n < 1100) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_first_valid_latency", n, 1029);
      for (int i = 0; i < 20; i++) begin
         check("bp_valid_held", out_valid, 1);
         check_fields("bp_stall", exp_q[0]);
         @(posedge clk); #1;
      end
      ready_force = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_dropped", out_valid, 0);
      wait_done(0, n);

      // Table of single-rectangle images with random consumer stalls
      rand_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         clear_mem();
         fill_rect(tbl[t].lbl, tbl[t].x0, tbl[t].x1, tbl[t].y0, tbl[t].y1);
         push_exp(tbl[t].lbl, tbl[t].x0, tbl[t].x1, tbl[t].y0, tbl[t].y1, tbl[t].area);
         pulse_start();
         wait_done(0, n);
         check("tbl_ovf", ovf, 0);
      end
      rand_ready = 1'b0;

      // Out-of-range labels raise ovf and are otherwise ignored
      clear_mem();
      mem[5]        = 8'd9;
      mem[700]      = 8'd9;
      mem[3*32 + 2] = 8'd1;
      mem[1023]     = 8'd255;
      push_exp(8'd1, 2, 2, 3, 3, 1);
      pulse_start();
      wait_done(0, n);
      check("ovf_set", ovf, 1);
      repeat (5) @(posedge clk);
      #1;
      check("ovf_sticky_idle", ovf, 1);

      clear_mem();
      pulse_start();
      @(posedge clk); #1;
      check("ovf_cleared_by_clear", ovf, 0);
      wait_done(1, n);
      check("ovf_clean_run", ovf, 0);

      // Abort mid-scan, then a fresh run while extra start pulses are ignored
      clear_mem();
      fill_rect(8'd2, 0, 31, 0, 31);
      pulse_start();
      n = 0;
      while (sram_a != 10'd500 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_reached_500", sram_a, 500);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_sram_a", sram_a, 0);
      check("abort_out_valid", out_valid, 0);
      reset = 1'b0;
      clear_mem();
      fill_rect(8'd4, 3, 6, 20, 22);
      push_exp(8'd4, 3, 6, 20, 22, 12);
      pulse_start();
      repeat (50) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(51, n);
      check("restart_done_latency", n, 1034);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
